bus_copy_master: RTL and testbench
==================================

Name: bus_copy_master

Overview:
- Bus initiator that sits on the master side of the shared BUS interconnect (m_req/m_grant, m_wr, m_addr, m_dout, m_din).
- On a start pulse it copies LEN consecutive 64-bit words from a source address range to a destination address range: one read and then one write per word.
- Used by the control path to move operands and results between the factorial core's slave windows and memory without CPU involvement.

Parameters:
- AW, 16, bus address width
- DW, 64, bus data width
- LW, 8, width of the word-count input

Ports:
- clk  input  1  system clock; single clock domain
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle command pulse; ignored while busy=1
- src_addr  input  AW  first source word address, sampled on start
- dst_addr  input  AW  first destination word address, sampled on start
- len  input  LW  number of words to copy, sampled on start; 0 is legal
- busy  output  1  high from the cycle after an accepted start through the DONE cycle
- done  output  1  one-cycle completion pulse
- m_req  output  1  bus request to the arbiter
- m_wr  output  1  1 = write, 0 = read
- m_addr  output  AW  bus address
- m_dout  output  DW  write data
- m_grant  input  1  arbiter grant; a beat completes only in a cycle where m_req=1 and m_grant=1
- m_din  input  DW  read data, valid the cycle after a granted read beat

Behaviour:
- All outputs are registered (Moore).
- Reset values: busy=0, done=0, m_req=0, m_wr=0, m_addr=0, m_dout=0, state=IDLE, counters cleared.
- Reset mid-transfer: on the next edge m_req drops to 0 and all outputs return to reset values. No done pulse. The partial copy is abandoned.
- States: IDLE, RD, RD_WAIT, WR, DONE.
- IDLE:
  - start=1 and len!=0: latch src, dst and len; go to RD.
  - start=1 and len=0: go to DONE; no bus activity.
- RD: m_req=1, m_wr=0, m_addr=cur_src.
  - m_grant=0: stay in RD and hold all outputs (retry).
  - m_grant=1: go to RD_WAIT.
- RD_WAIT: m_req=1, m_wr=0, m_addr still cur_src so the BUS read mux stays steered. Capture m_din into the data buffer and go to WR unconditionally; m_grant is ignored in this state.
- WR: m_req=1, m_wr=1, m_addr=cur_dst, m_dout=buffer.
  - m_grant=0: stay in WR and hold.
  - m_grant=1: increment cur_src and cur_dst (modulo 2^AW; 0xFFFF wraps to 0x0000) and decrement remaining. If remaining was 1 go to DONE, else go to RD.
- m_req stays high between words; the bus is not released mid-copy.
- DONE: m_req=0, m_wr=0, done=1 for exactly one cycle, busy=1; then IDLE.
- Latency with continuous grant: N words take 3N cycles in RD/RD_WAIT/WR. done is high in cycle 3N+1 after the start edge. For len=0, done is high in cycle 1.
- start during busy (including the DONE cycle) is dropped, not queued.
- m_dout changes only on entry to WR. m_addr changes only on state transitions.

Decomposition:
- Shared package bus_pkg: AW and DW constants, the state encoding for bus_copy_master, and the slave address-map constants (s0/s1 window bases) shared with BUS.
- No sub-module needed. Counters and address incrementers stay inline.

Test Plan:
- Single word, grant tied 1: start, src=0x0011, dst=0x0100, len=1; slave returns 0x6 → read beat at 0x0011, then write at 0x0100 with m_dout=0x6, done in cycle 4, m_req low from cycle 4.
- Burst, grant tied 1: len=3, src=0x0010, dst=0x0200, slave data 7,8,9 → writes 0x0200=7, 0x0201=8, 0x0202=9; done in cycle 10; m_req continuously high in cycles 1-9.
- Grant stall: len=1, m_grant=0 for 4 cycles in RD and 2 cycles in WR → m_addr and m_wr held constant throughout; done in cycle 4+6=10; exactly one write observed.
- len=0 and start while busy: len=0 → done in cycle 1 with m_req never asserted. A second start issued mid-copy with a different src is ignored; the copy completes with the original addresses.
- Wrap and reset: src=0xFFFF, len=2 → reads 0xFFFF then 0x0000. Separately, reset asserted in a WR cycle of word 2 → m_req=0, busy=0, done never pulses, and the next start works normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus constants: widths, slave window map and the copy-master state encoding.
package bus_pkg;

   localparam int unsigned BusAw  = 16;
   localparam int unsigned BusDw  = 64;
   localparam int unsigned CopyLw = 8;

   // Slave windows decoded by the BUS interconnect; everything else routes to memory.
   localparam logic [BusAw-1:0] S0Base    = 16'h1000;
   localparam logic [BusAw-1:0] S1Base    = 16'h2000;
   localparam logic [BusAw-1:0] SWinWords = 16'h0100;

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StRdWait,
      StWr,
      StDone
   } copy_state_e;

   function automatic logic in_window(input logic [BusAw-1:0] addr,
                                      input logic [BusAw-1:0] base);
      return (addr >= base) && (addr < base + SWinWords);
   endfunction

endpackage

// File: rtl/bus_copy_master.sv
// Bus initiator copying LEN 64-bit words from src to dst, one read then one write per word.
// All outputs are registered; the bus is held (m_req=1) for the whole copy.
module bus_copy_master
   import bus_pkg::*;
#(
   parameter int unsigned AW = BusAw,
   parameter int unsigned DW = BusDw,
   parameter int unsigned LW = CopyLw
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [LW-1:0] len,
   output logic          busy,
   output logic          done,
   output logic          m_req,
   output logic          m_wr,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_dout,
   input  logic          m_grant,
   input  logic [DW-1:0] m_din
);

   copy_state_e   r_state;
   logic [AW-1:0] r_cur_src;
   logic [AW-1:0] r_cur_dst;
   logic [LW-1:0] r_remaining;
   logic          r_busy;
   logic          r_done;
   logic          r_req;
   logic          r_wr;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_dout;

   logic [AW-1:0] w_src_next;
   logic [AW-1:0] w_dst_next;
   logic          w_last;

   // Address increments wrap modulo 2^AW by truncation.
   assign w_src_next = r_cur_src + AW'(1);
   assign w_dst_next = r_cur_dst + AW'(1);
   assign w_last     = (r_remaining == LW'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= StIdle;
         r_cur_src   <= '0;
         r_cur_dst   <= '0;
         r_remaining <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_req       <= 1'b0;
         r_wr        <= 1'b0;
         r_addr      <= '0;
         r_dout      <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (start) begin
                  r_busy <= 1'b1;
                  if (len != '0) begin
                     r_cur_src   <= src_addr;
                     r_cur_dst   <= dst_addr;
                     r_remaining <= len;
                     r_req       <= 1'b1;
                     r_wr        <= 1'b0;
                     r_addr      <= src_addr;
                     r_state     <= StRd;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= StDone;
                  end
               end
            end
            StRd: begin
               if (m_grant) begin
                  r_state <= StRdWait;
               end
            end
            StRdWait: begin
               // Read data arrives one cycle after the granted beat; m_addr stays on src.
               r_dout  <= m_din;
               r_wr    <= 1'b1;
               r_addr  <= r_cur_dst;
               r_state <= StWr;
            end
            StWr: begin
               if (m_grant) begin
                  r_cur_src   <= w_src_next;
                  r_cur_dst   <= w_dst_next;
                  r_remaining <= r_remaining - LW'(1);
                  r_wr        <= 1'b0;
                  if (w_last) begin
                     r_req   <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= StDone;
                  end else begin
                     r_addr  <= w_src_next;
                     r_state <= StRd;
                  end
               end
            end
            StDone: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign m_req  = r_req;
   assign m_wr   = r_wr;
   assign m_addr = r_addr;
   assign m_dout = r_dout;

endmodule

// File: tb/tb_bus_copy_master.sv
// Self-checking bench for bus_copy_master: a bus slave model with a fixed memory image,
// scheduled or random grant stalls, and a reference of the expected read/write sequence.
module tb_bus_copy_master;
   import bus_pkg::*;

   localparam int unsigned AW = BusAw;
   localparam int unsigned DW = BusDw;
   localparam int unsigned LW = CopyLw;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] src_addr;
   logic [AW-1:0] dst_addr;
   logic [LW-1:0] len;
   logic          busy;
   logic          done;
   logic          m_req;
   logic          m_wr;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_dout;
   logic          m_grant;
   logic [DW-1:0] m_din;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bus_copy_master #(.AW(AW), .DW(DW), .LW(LW)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .src_addr (src_addr),
      .dst_addr (dst_addr),
      .len      (len),
      .busy     (busy),
      .done     (done),
      .m_req    (m_req),
      .m_wr     (m_wr),
      .m_addr   (m_addr),
      .m_dout   (m_dout),
      .m_grant  (m_grant),
      .m_din    (m_din)
   );

   // Slave memory image is fixed; writes are logged rather than stored.
   logic [DW-1:0] mem [logic [AW-1:0]];

   function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
      if (mem.exists(a)) return mem[a];
      return {16'hC0DE, a, 32'(a) * 32'h9E37_79B1};
   endfunction

   // Observation state, updated once per cycle by step().
   int            cyc;
   logic [AW-1:0] rd_log[$];
   logic [AW-1:0] wr_addr_log[$];
   logic [DW-1:0] wr_data_log[$];
   int            done_cyc, done_cnt, stall_cnt, hold_err;
   bit            prev_rd_beat, pend_rd, prev_stall, rand_grant;
   logic [AW-1:0] pend_addr, prev_addr;
   logic          prev_wr;
   logic [DW-1:0] prev_dout;
   int            rd_stall_left, wr_stall_left;

   task automatic clear_obs();
      rd_log.delete();
      wr_addr_log.delete();
      wr_data_log.delete();
      done_cyc      = -1;
      done_cnt      = 0;
      stall_cnt     = 0;
      hold_err      = 0;
      prev_rd_beat  = 0;
      pend_rd       = 0;
      prev_stall    = 0;
      rd_stall_left = 0;
      wr_stall_left = 0;
      rand_grant    = 0;
   endtask

   // Advance to the next falling edge, observe that cycle's outputs, act as slave/arbiter.
   task automatic step();
      bit rd_phase, wr_phase;
      @(negedge clk);
      cyc++;
      if (prev_stall && (m_addr !== prev_addr || m_wr !== prev_wr ||
                         (prev_wr && m_dout !== prev_dout))) hold_err++;
      m_din = pend_rd ? slave_data(pend_addr) : {$urandom, $urandom};
      pend_rd  = 0;
      rd_phase = m_req && !m_wr && !prev_rd_beat;
      wr_phase = m_req && m_wr;
      if (rd_phase && rd_stall_left > 0) begin
         m_grant = 1'b0;
         rd_stall_left--;
      end else if (wr_phase && wr_stall_left > 0) begin
         m_grant = 1'b0;
         wr_stall_left--;
      end else if (rand_grant) begin
         m_grant = ($urandom_range(0, 2) != 0);
      end else begin
         m_grant = 1'b1;
      end
      prev_stall = (rd_phase || wr_phase) && !m_grant;
      if (prev_stall) stall_cnt++;
      prev_addr    = m_addr;
      prev_wr      = m_wr;
      prev_dout    = m_dout;
      prev_rd_beat = rd_phase && m_grant;
      if (prev_rd_beat) begin
         rd_log.push_back(m_addr);
         pend_rd   = 1;
         pend_addr = m_addr;
      end
      if (wr_phase && m_grant) begin
         wr_addr_log.push_back(m_addr);
         wr_data_log.push_back(m_dout);
      end
      if (done) begin
         done_cnt++;
         if (done_cyc < 0) done_cyc = cyc;
      end
   endtask

   // One full copy; inj_cyc >= 2 re-pulses start (different src) in that cycle.
   task automatic run_copy(input string name, input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input int n, input int rd_st, input int wr_st, input bit rnd,
                           input int inj_cyc);
      int exp_done, budget, req_err, busy_err, nrd, nwr;
      logic [AW-1:0] ea;
      clear_obs();
      rd_stall_left = rd_st;
      wr_stall_left = wr_st;
      rand_grant    = rnd;
      req_err       = 0;
      busy_err      = 0;
      budget        = 12 * n + 64;
      start    = 1'b1;
      src_addr = s;
      dst_addr = d;
      len      = LW'(n);
      cyc      = 0;
      while (cyc < budget && done_cyc < 0) begin
         step();
         if (cyc == 1) begin
            src_addr = ~s;
            dst_addr = ~d;
            len      = LW'(n + 1);
         end
         start = (cyc == inj_cyc);
         if (start) src_addr = s ^ 16'h0F0F;
         if (busy !== 1'b1) busy_err++;
         if (done_cyc < 0 && m_req !== (n != 0)) req_err++;
         if (done_cyc > 0 && m_req !== 1'b0) req_err++;
      end
      start = 1'b0;
      repeat (2) begin
         step();
         checks++;
         if (busy !== 1'b0 || m_req !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s post_idle: busy=%b m_req=%b done=%b required 0/0/0",
                     name, busy, m_req, done);
         end
      end
      exp_done = (n == 0) ? 1 : 3 * n + 1 + (rnd ? stall_cnt : rd_st + wr_st);
      checks++;
      if (done_cyc !== exp_done) begin
         failures++;
         $display("FAIL %s done_cycle: got %0d required %0d", name, done_cyc, exp_done);
      end
      checks++;
      if (done_cnt !== 1) begin
         failures++;
         $display("FAIL %s done_count: got %0d required 1", name, done_cnt);
      end
      checks++;
      if (req_err !== 0 || busy_err !== 0 || hold_err !== 0) begin
         failures++;
         $display("FAIL %s profile: req_err=%0d busy_err=%0d hold_err=%0d required 0",
                  name, req_err, busy_err, hold_err);
      end
      nrd = rd_log.size();
      nwr = wr_addr_log.size();
      checks++;
      if (nrd !== n || nwr !== n) begin
         failures++;
         $display("FAIL %s beat_count: reads=%0d writes=%0d required %0d", name, nrd, nwr, n);
      end
      for (int i = 0; i < n; i++) begin
         ea = 16'(int'(s) + i);
         if (i < nrd) begin
            checks++;
            if (rd_log[i] !== ea) begin
               failures++;
               $display("FAIL %s read_addr[%0d]: got %h required %h", name, i, rd_log[i], ea);
            end
         end
         if (i < nwr) begin
            checks++;
            if (wr_addr_log[i] !== 16'(int'(d) + i) || wr_data_log[i] !== slave_data(ea)) begin
               failures++;
               $display("FAIL %s write[%0d]: got %h=%h required %h=%h", name, i, wr_addr_log[i],
                        wr_data_log[i], 16'(int'(d) + i), slave_data(ea));
            end
         end
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      start    = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      len      = '0;
      m_grant  = 1'b1;
      m_din    = '0;
      clear_obs();
      repeat (3) step();
      checks++;
      if ({busy, done, m_req, m_wr} !== 4'b0 || m_addr !== '0 || m_dout !== '0) begin
         failures++;
         $display("FAIL reset_values: busy=%b done=%b req=%b wr=%b addr=%h dout=%h required 0",
                  busy, done, m_req, m_wr, m_addr, m_dout);
      end
      reset = 1'b0;
      repeat (3) step();
      checks++;
      if ({busy, done, m_req} !== 3'b0) begin
         failures++;
         $display("FAIL idle_no_start: busy=%b done=%b req=%b required 000", busy, done, m_req);
      end
   endtask

   task automatic test_single();
      mem[16'h0011] = 64'h6;
      run_copy("single", 16'h0011, 16'h0100, 1, 0, 0, 0, -1);
   endtask

   task automatic test_burst();
      mem[16'h0010] = 64'h7;
      mem[16'h0011] = 64'h8;
      mem[16'h0012] = 64'h9;
      run_copy("burst", 16'h0010, 16'h0200, 3, 0, 0, 0, -1);
   endtask

   task automatic test_grant_stall();
      run_copy("stall", 16'h0011, 16'h0300, 1, 4, 2, 0, -1);
      run_copy("stall_burst", 16'h0020, 16'h0320, 3, 3, 5, 0, -1);
   endtask

   task automatic test_len_zero_and_busy_start();
      run_copy("len_zero", 16'h0005, 16'h0006, 0, 0, 0, 0, -1);
      run_copy("start_mid", 16'h0040, 16'h0400, 4, 0, 0, 0, 5);
      run_copy("start_in_done", 16'h0050, 16'h0500, 4, 0, 0, 0, 13);
   endtask

   task automatic test_wrap();
      run_copy("wrap", 16'hFFFF, 16'hFFFE, 2, 0, 0, 0, -1);
   endtask

   task automatic test_reset_mid();
      clear_obs();
      start    = 1'b1;
      src_addr = 16'h0080;
      dst_addr = 16'h0800;
      len      = LW'(3);
      cyc      = 0;
      step();
      start = 1'b0;
      while (cyc < 6) step();
      checks++;
      if (m_wr !== 1'b1 || m_addr !== 16'h0801) begin
         failures++;
         $display("FAIL reset_mid_setup: wr=%b addr=%h required 1/0801", m_wr, m_addr);
      end
      reset = 1'b1;
      step();
      checks++;
      if (m_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || m_wr !== 1'b0 ||
          m_addr !== '0 || m_dout !== '0) begin
         failures++;
         $display("FAIL reset_mid_outputs: req=%b busy=%b done=%b wr=%b addr=%h dout=%h req 0",
                  m_req, busy, done, m_wr, m_addr, m_dout);
      end
      step();
      reset = 1'b0;
      repeat (4) step();
      checks++;
      if (done_cnt !== 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_no_done: done_cnt=%0d busy=%b required 0/0", done_cnt, busy);
      end
      run_copy("after_reset", 16'h0090, 16'h0900, 2, 0, 0, 0, -1);
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++) begin
         run_copy($sformatf("rand%0d", k), 16'($urandom), 16'($urandom),
                  (k == 3) ? 0 : int'($urandom_range(1, 12)), 0, 0, 1, -1);
      end
   endtask

   task automatic test_back_to_back();
      run_copy("b2b_a", 16'h1000, 16'h3000, 2, 0, 0, 0, -1);
      run_copy("b2b_b", 16'h1002, 16'h3002, 2, 1, 1, 0, -1);
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_grant_stall();
      test_len_zero_and_busy_start();
      test_wrap();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
